// File: rtl/neopix_frame_sched_pkg.sv
// Shared constants for the two-channel neopixel frame scheduler: channel count,
// timing defaults, FSM state codes and the frame-level round-robin pick.
package neopix_pkg;

    localparam int NUM_CH             = 2;
    localparam int DEF_RESET_CYCLES   = 14000;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_LATCH  = 2'd3;

    // Only called with at least one request pending; a lone request always wins.
    function automatic logic rr_pick(input logic [NUM_CH-1:0] valid, input logic last_served);
        if (&valid) return ~last_served;
        return valid[1];
    endfunction

endpackage

// File: rtl/neopix_frame_sched_if.sv
// Channel byte streams in, one shared encoder byte stream out.
// master = pixel sources plus encoder; slave = the scheduler.
interface neopix_frame_sched_if;
    import neopix_pkg::*;

    logic [NUM_CH-1:0][7:0] ch_data;
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH-1:0]      ch_last;
    logic [NUM_CH-1:0]      ch_ready;
    logic [7:0]             enc_data;
    logic                   enc_valid;
    logic                   enc_ready;
    logic                   enc_busy;
    logic                   enc_sel;

    modport master (
        output ch_data, ch_valid, ch_last, enc_ready, enc_busy,
        input  ch_ready, enc_data, enc_valid, enc_sel
    );

    modport slave (
        input  ch_data, ch_valid, ch_last, enc_ready, enc_busy,
        output ch_ready, enc_data, enc_valid, enc_sel
    );

endinterface

// File: rtl/neopix_frame_sched_timer.sv
// Loadable down-counter that parks at zero; shared between the in-frame idle
// timeout and the latch low period.
module neopix_cycle_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    // NOTE: count_d is given a default before any branch so this block stays purely combinational (no latch).
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: registered state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/neopix_frame_sched.sv
// Frame-level round-robin scheduler sharing one neopixel encoder between two
// pixel streams, with an in-frame idle timeout and a latch low period per frame.
module neopix_frame_sched
    import neopix_pkg::*;
#(
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    neopix_frame_sched_if.slave      bus,
    output logic                     busy,
    output logic [NUM_CH-1:0]        timeout_err
);

    localparam int CNT_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(RESET_CYCLES - 1);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q,  last_d;
    logic [NUM_CH-1:0] err_q,   err_d;

    logic              timer_load, timer_en, timer_done;
    logic [CNT_W-1:0]  timer_val;
    logic              in_stream, g_valid, accept;
    logic [NUM_CH-1:0] ready_vec;

    assign in_stream = (state_q == ST_STREAM);
    assign g_valid   = bus.ch_valid[grant_q];
    assign accept    = in_stream & g_valid & bus.enc_ready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        err_d      = err_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.ch_valid) begin
                    grant_d    = rr_pick(bus.ch_valid, last_q);
                    state_d    = ST_STREAM;
                    timer_load = 1'b1;
                    timer_val  = TO_LOAD;
                end
            end
            ST_STREAM: begin
                timer_en = 1'b1;
                // An accepted byte outranks a timeout expiring in the same cycle.
                if (accept) begin
                    timer_load = 1'b1;
                    timer_val  = TO_LOAD;
                    if (bus.ch_last[grant_q]) state_d = ST_DRAIN;
                end else if (timer_done) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.enc_busy) begin
                    state_d    = ST_LATCH;
                    timer_load = 1'b1;
                    timer_val  = LATCH_LOAD;
                end
            end
            ST_LATCH: begin
                timer_en = 1'b1;
                if (timer_done) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    neopix_cycle_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .done     (timer_done)
    );

    always_comb begin
        ready_vec = '0;
        if (in_stream) ready_vec[grant_q] = bus.enc_ready & g_valid;
    end

    assign bus.ch_ready  = ready_vec;
    assign bus.enc_valid = in_stream & g_valid;
    assign bus.enc_data  = in_stream ? bus.ch_data[grant_q] : 8'h00;
    assign bus.enc_sel   = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_err   = err_q;

endmodule

// File: doc/neopix_frame_sched.md
NEOPIX_FRAME_SCHED -- requirements
Module: neopix_frame_sched

Interface
REQ-001 Parameter RESET_CYCLES, default 14000, latch low time in clk cycles (280 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000, maximum idle gap inside a frame before forced frame end.
REQ-003 clk  input  1  single system clock (50 MHz); all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_data  input  2x8  per-channel pixel byte (index 0 = SSEL0 stream, 1 = SSEL1 stream).
REQ-006 ch_valid  input  2  per-channel byte valid.
REQ-007 ch_last  input  2  per-channel last-byte-of-frame flag, qualified by ch_valid.
REQ-008 ch_ready  output  2  per-channel byte accepted this cycle.
REQ-009 enc_data  output  8  byte to shared neopixel encoder.
REQ-010 enc_valid  output  1  enc_data valid.
REQ-011 enc_ready  input  1  encoder can accept a byte.
REQ-012 enc_busy  input  1  encoder still shifting bits out.
REQ-013 enc_sel  output  1  which DO pin (DO0/DO1) the encoder drives.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  2  sticky per-channel frame-timeout flag.

Function
REQ-016 States: IDLE, STREAM, DRAIN, LATCH; all other encodings return to IDLE.
REQ-017 IDLE: when any ch_valid is high, the block registers grant and moves to STREAM on the next edge; grant is registered, so one cycle of arbitration latency.
REQ-018 Arbitration: round-robin at frame granularity; with both ch_valid high, the channel not served last wins; with one valid, that channel wins.
REQ-019 STREAM: enc_valid = ch_valid[grant], enc_data = ch_data[grant], ch_ready[grant] = enc_ready & ch_valid[grant], combinational pass-through with zero latency.
REQ-020 ch_ready of the non-granted channel is 0 in every state; ch_ready is 0 outside STREAM.
REQ-021 enc_sel equals grant and holds its value through DRAIN and LATCH.
REQ-022 STREAM exits to DRAIN on the cycle that accepts a byte with ch_last[grant] = 1.
REQ-023 STREAM idle counter clears on each accepted byte; on reaching TIMEOUT_CYCLES, the block sets timeout_err[grant] and goes to DRAIN.
REQ-024 If the accepting byte and the timeout occur in the same cycle, the byte wins and timeout_err is not set.
REQ-025 DRAIN: enc_valid = 0; the block moves to LATCH on the first cycle enc_busy = 0.
REQ-026 LATCH: enc_valid = 0; counter runs from 0 to RESET_CYCLES-1; the block then goes to IDLE and records last-served = grant.
REQ-027 Requests arriving during DRAIN or LATCH wait; no byte is accepted until the next STREAM.
REQ-028 timeout_err bits clear only on reset.

Reset
REQ-029 Asynchronous rst forces IDLE, grant = 0, last-served = 1 (channel 0 first), counters = 0, enc_valid = 0, ch_ready = 0, enc_sel = 0, busy = 0, timeout_err = 0.
REQ-030 Reset mid-frame abandons the frame; no latch period is owed afterwards.

Structure
REQ-031 Package neopix_pkg holds the state enum, the channel count (2) and the default values of RESET_CYCLES and TIMEOUT_CYCLES.
REQ-032 One sub-module, neopix_cycle_timer (loadable down-counter with done flag), is shared by the idle timeout and the latch count.

Verification
REQ-033 Ch0 sends bytes AA,55,00 with last on 00; enc_ready = 1 -> enc_data sees AA,55,00 in order, enc_sel = 0, then DRAIN, then exactly 14000 LATCH cycles, then IDLE.
REQ-034 Ch0 and ch1 both valid after reset -> ch0 is served first; ch1 frame (00,55,AA) follows after ch0 latch with enc_sel = 1.
REQ-035 Ch1 sends one byte and goes silent -> after 50000 cycles timeout_err = 2'b10, DRAIN then LATCH, and the next frame is accepted normally.
REQ-036 enc_ready is held low for 10 cycles mid-frame -> ch_ready[grant] = 0 for those cycles, no bytes lost or duplicated.
REQ-037 rst is asserted during the second byte of a ch1 frame -> all outputs reach reset values immediately, and a ch0 request afterwards is granted.
REQ-038 ch_valid[1] is raised during ch0 LATCH -> ch_ready[1] = 0 until the ch1 STREAM starts one cycle after IDLE.
